// File: rtl/tournament_br_predictor_pkg.sv
// -----------------------------------------------------------------------------
// tournament_br_predictor_pkg
// Shared types and default parameters for the tournament branch predictor.
//   - default table/counter/history sizes used as parameter defaults
//   - br_pred / tn_predictor encodings for the 2-bit default counters
//   - br_pred_info_t: per-branch prediction info carried down the pipeline
// -----------------------------------------------------------------------------
package tournament_br_predictor_pkg;

    localparam int BR_LC_IDX_BITS = 6;
    localparam int BR_GL_IDX_BITS = 8;
    localparam int BR_CTR_WIDTH   = 2;
    localparam int BR_SEL_WIDTH   = 2;

    // 2-bit direction counter encoding; MSB is the predicted direction.
    typedef enum logic [1:0] {
        strongly_not_taken = 2'b00,
        weakly_not_taken   = 2'b01,
        weakly_taken       = 2'b10,
        strongly_taken     = 2'b11
    } br_pred;

    // 2-bit chooser encoding; MSB = 1 selects the global (gshare) table.
    typedef enum logic [1:0] {
        use_lc_predictor_1 = 2'b00,
        use_lc_predictor_2 = 2'b01,
        use_gl_predictor_2 = 2'b10,
        use_gl_predictor_1 = 2'b11
    } tn_predictor;

    typedef struct packed {
        logic                      taken;
        logic                      lc_dir;
        logic                      gl_dir;
        logic [BR_GL_IDX_BITS-1:0] ghr;
    } br_pred_info_t;

endpackage

// File: rtl/tournament_br_predictor_counter_table.sv
// -----------------------------------------------------------------------------
// br_counter_table
// Flop array of saturating up/down counters, one combinational read port and
// one write port that nudges the addressed counter up or down by one.
// Ports:
//   clk, rst        clock, synchronous active-high reset (all entries -> RST_VAL)
//   rd_idx, rd_ctr  combinational read
//   wr_en, wr_idx   update enable and address
//   wr_up           1 = increment, 0 = decrement (both saturate)
// -----------------------------------------------------------------------------
module br_counter_table #(
    parameter int                 IDX_BITS = 6,
    parameter int                 WIDTH    = 2,
    parameter logic [WIDTH-1:0]   RST_VAL  = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic [WIDTH-1:0]    rd_ctr,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic                wr_up
);

    localparam int               DEPTH   = 2 ** IDX_BITS;
    localparam logic [WIDTH-1:0] CTR_MAX = '1;
    localparam logic [WIDTH-1:0] CTR_MIN = '0;
    localparam logic [WIDTH-1:0] CTR_ONE = WIDTH'(1);

    logic [WIDTH-1:0] ctr_q [DEPTH];
    logic [WIDTH-1:0] wr_old;

    // No bypass: a same-cycle read of the written entry sees the old value.
    assign rd_ctr = ctr_q[rd_idx];
    assign wr_old = ctr_q[wr_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= RST_VAL;
            end
        end else if (wr_en) begin
            if (wr_up) begin
                if (wr_old != CTR_MAX) ctr_q[wr_idx] <= wr_old + CTR_ONE;
            end else begin
                if (wr_old != CTR_MIN) ctr_q[wr_idx] <= wr_old - CTR_ONE;
            end
        end
    end

endmodule

// File: rtl/tournament_br_predictor.sv
// -----------------------------------------------------------------------------
// tournament_br_predictor
// Tournament predictor: PC-indexed bimodal table, gshare table and PC-indexed
// chooser. Prediction is combinational from pred_pc; training on upd_valid.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   pred_valid, pred_pc            fetch-side branch qualifier and PC
//   pred_taken                     final direction
//   pred_lc_dir, pred_gl_dir       per-table directions (carry to update port)
//   pred_ghr                       history snapshot used (carry to update port)
//   upd_valid, upd_pc, upd_taken   resolved branch
//   upd_lc_dir, upd_gl_dir, upd_ghr  prediction-time info of that branch
//   upd_mispredict                 final prediction was wrong
// Build option: define BR_PRED_SPEC_GHR_EN for a speculative GHR that shifts
// at prediction and is repaired on mispredict; default updates the GHR only
// at resolve time.
// -----------------------------------------------------------------------------
module tournament_br_predictor
    import tournament_br_predictor_pkg::*;
#(
    parameter int LC_IDX_BITS = BR_LC_IDX_BITS,
    parameter int GL_IDX_BITS = BR_GL_IDX_BITS,
    parameter int CTR_WIDTH   = BR_CTR_WIDTH,
    parameter int SEL_WIDTH   = BR_SEL_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pred_valid,
    input  logic [31:0]            pred_pc,
    output logic                   pred_taken,
    output logic                   pred_lc_dir,
    output logic                   pred_gl_dir,
    output logic [GL_IDX_BITS-1:0] pred_ghr,
    input  logic                   upd_valid,
    input  logic [31:0]            upd_pc,
    input  logic                   upd_taken,
    input  logic                   upd_lc_dir,
    input  logic                   upd_gl_dir,
    input  logic [GL_IDX_BITS-1:0] upd_ghr,
    input  logic                   upd_mispredict
);

    // Weakly-not-taken / weakly-use-local: 0 followed by all ones.
    localparam logic [CTR_WIDTH-1:0] CTR_RST = {1'b0, {(CTR_WIDTH-1){1'b1}}};
    localparam logic [SEL_WIDTH-1:0] SEL_RST = {1'b0, {(SEL_WIDTH-1){1'b1}}};

    logic [GL_IDX_BITS-1:0] ghr_q;

    logic [LC_IDX_BITS-1:0] pred_lc_idx;
    logic [GL_IDX_BITS-1:0] pred_gl_idx;
    logic [LC_IDX_BITS-1:0] upd_lc_idx;
    logic [GL_IDX_BITS-1:0] upd_gl_idx;

    logic [CTR_WIDTH-1:0]   lc_ctr;
    logic [CTR_WIDTH-1:0]   gl_ctr;
    logic [SEL_WIDTH-1:0]   sel_ctr;

    logic                   sel_wr_en;
    logic                   sel_wr_up;

    assign pred_lc_idx = pred_pc[LC_IDX_BITS+1:2];
    assign pred_gl_idx = pred_pc[GL_IDX_BITS+1:2] ^ ghr_q;
    assign upd_lc_idx  = upd_pc[LC_IDX_BITS+1:2];
    assign upd_gl_idx  = upd_pc[GL_IDX_BITS+1:2] ^ upd_ghr;

    // Chooser only learns when the two tables disagreed; it moves toward
    // whichever table was right.
    assign sel_wr_en = upd_valid && (upd_lc_dir != upd_gl_dir);
    assign sel_wr_up = (upd_gl_dir == upd_taken);

    br_counter_table #(
        .IDX_BITS (LC_IDX_BITS),
        .WIDTH    (CTR_WIDTH),
        .RST_VAL  (CTR_RST)
    ) u_lc_table (
        .clk    (clk),
        .rst    (rst),
        .rd_idx (pred_lc_idx),
        .rd_ctr (lc_ctr),
        .wr_en  (upd_valid),
        .wr_idx (upd_lc_idx),
        .wr_up  (upd_taken)
    );

    br_counter_table #(
        .IDX_BITS (GL_IDX_BITS),
        .WIDTH    (CTR_WIDTH),
        .RST_VAL  (CTR_RST)
    ) u_gl_table (
        .clk    (clk),
        .rst    (rst),
        .rd_idx (pred_gl_idx),
        .rd_ctr (gl_ctr),
        .wr_en  (upd_valid),
        .wr_idx (upd_gl_idx),
        .wr_up  (upd_taken)
    );

    br_counter_table #(
        .IDX_BITS (LC_IDX_BITS),
        .WIDTH    (SEL_WIDTH),
        .RST_VAL  (SEL_RST)
    ) u_sel_table (
        .clk    (clk),
        .rst    (rst),
        .rd_idx (pred_lc_idx),
        .rd_ctr (sel_ctr),
        .wr_en  (sel_wr_en),
        .wr_idx (upd_lc_idx),
        .wr_up  (sel_wr_up)
    );

    assign pred_lc_dir = lc_ctr[CTR_WIDTH-1];
    assign pred_gl_dir = gl_ctr[CTR_WIDTH-1];
    assign pred_taken  = sel_ctr[SEL_WIDTH-1] ? pred_gl_dir : pred_lc_dir;
    assign pred_ghr    = ghr_q;

`ifdef BR_PRED_SPEC_GHR_EN
    // Repair from the mispredicted branch's snapshot wins over a new shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q <= '0;
        end else if (upd_valid && upd_mispredict) begin
            ghr_q <= {upd_ghr[GL_IDX_BITS-2:0], upd_taken};
        end else if (pred_valid) begin
            ghr_q <= {ghr_q[GL_IDX_BITS-2:0], pred_taken};
        end
    end

    logic unused_ok;
    assign unused_ok = ^{pred_pc, upd_pc};
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q <= '0;
        end else if (upd_valid) begin
            ghr_q <= {ghr_q[GL_IDX_BITS-2:0], upd_taken};
        end
    end

    logic unused_ok;
    assign unused_ok = ^{pred_pc, upd_pc, pred_valid, upd_mispredict};
`endif

endmodule

// File: tb/tb_tournament_br_predictor.sv
module tb_tournament_br_predictor;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        pred_lc_dir;
    logic        pred_gl_dir;
    logic [7:0]  pred_ghr;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_lc_dir;
    logic        upd_gl_dir;
    logic [7:0]  upd_ghr;
    logic        upd_mispredict;

    tournament_br_predictor dut (
        .clk            (clk),
        .rst            (rst),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken),
        .pred_lc_dir    (pred_lc_dir),
        .pred_gl_dir    (pred_gl_dir),
        .pred_ghr       (pred_ghr),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_lc_dir     (upd_lc_dir),
        .upd_gl_dir     (upd_gl_dir),
        .upd_ghr        (upd_ghr),
        .upd_mispredict (upd_mispredict)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: counters as plain integers 0..3, history as an integer.
    int loc_m [64];
    int glb_m [256];
    int cho_m [64];
    int ghr_m;

    function automatic int sat(input int v);
        return (v < 0) ? 0 : ((v > 3) ? 3 : v);
    endfunction

    function automatic int lidx(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic int gidx(input logic [31:0] pc, input int h);
        return int'((pc >> 2) % 256) ^ h;
    endfunction

    function automatic logic m_lc(input logic [31:0] pc);
        return loc_m[lidx(pc)] >= 2;
    endfunction

    function automatic logic m_gl(input logic [31:0] pc);
        return glb_m[gidx(pc, ghr_m)] >= 2;
    endfunction

    function automatic logic m_taken(input logic [31:0] pc);
        return (cho_m[lidx(pc)] >= 2) ? m_gl(pc) : m_lc(pc);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            loc_m[i] = 1;
            cho_m[i] = 1;
        end
        for (int i = 0; i < 256; i++) glb_m[i] = 1;
        ghr_m = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic [31:0] ppc, input logic uv,
                         input logic [31:0] upc, input logic ut, input logic ulc,
                         input logic ugl, input logic [7:0] ughr, input logic umis);
        pred_valid     = pv;
        pred_pc        = ppc;
        upd_valid      = uv;
        upd_pc         = upc;
        upd_taken      = ut;
        upd_lc_dir     = ulc;
        upd_gl_dir     = ugl;
        upd_ghr        = ughr;
        upd_mispredict = umis;
        #1;
    endtask

    task automatic check_model();
        chk("pred_taken",  {31'd0, pred_taken},  {31'd0, m_taken(pred_pc)});
        chk("pred_lc_dir", {31'd0, pred_lc_dir}, {31'd0, m_lc(pred_pc)});
        chk("pred_gl_dir", {31'd0, pred_gl_dir}, {31'd0, m_gl(pred_pc)});
        chk("pred_ghr",    {24'd0, pred_ghr},    32'(ghr_m));
    endtask

    // Advance one clock and apply the same cycle to the model.
    task automatic tick();
        logic t_pred;
        int   li, gi;
        t_pred = m_taken(pred_pc);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (upd_valid) begin
                li = lidx(upd_pc);
                gi = gidx(upd_pc, int'(upd_ghr));
                loc_m[li] = sat(loc_m[li] + (upd_taken ? 1 : -1));
                glb_m[gi] = sat(glb_m[gi] + (upd_taken ? 1 : -1));
                if (upd_lc_dir != upd_gl_dir)
                    cho_m[li] = sat(cho_m[li] + ((upd_gl_dir == upd_taken) ? 1 : -1));
            end
`ifdef BR_PRED_SPEC_GHR_EN
            if (upd_valid && upd_mispredict)
                ghr_m = ((int'(upd_ghr) << 1) | int'(upd_taken)) % 256;
            else if (pred_valid)
                ghr_m = ((ghr_m << 1) | int'(t_pred)) % 256;
`else
            if (upd_valid)
                ghr_m = ((ghr_m << 1) | int'(upd_taken)) % 256;
`endif
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 32'h40, 0, 32'h0, 0, 0, 0, 8'h00, 0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 32'h0, 0, 32'h0, 0, 0, 0, 8'h00, 0);
        model_reset();

        // Reset state; rst also overrides a simultaneous update.
        rst = 1'b1;
        drive(0, 32'h40, 1, 32'h40, 1, 0, 1, 8'h00, 1);
        tick();
        rst = 1'b0;
        drive(0, 32'h40, 0, 32'h0, 0, 0, 0, 8'h00, 0);
        check_model();
        chk("rst_taken", {31'd0, pred_taken},  32'd0);
        chk("rst_lc",    {31'd0, pred_lc_dir}, 32'd0);
        chk("rst_gl",    {31'd0, pred_gl_dir}, 32'd0);
        chk("rst_ghr",   {24'd0, pred_ghr},    32'd0);
        tick();

        // Local saturation at 0x40, tables agreeing so chooser stays put.
        drive(0, 32'h40, 1, 32'h40, 1, 0, 0, 8'h00, 0);
        check_model();
        tick();
        drive(0, 32'h40, 1, 32'h40, 1, 0, 0, 8'h00, 0);
        check_model();
        chk("lc_after_first_upd", {31'd0, pred_lc_dir}, 32'd1);
        tick();
        drive(0, 32'h40, 1, 32'h40, 1, 0, 0, 8'h00, 0);
        check_model();
        tick();
        drive(0, 32'h40, 0, 32'h0, 0, 0, 0, 8'h00, 0);
        check_model();
        chk("lc_saturated",       {31'd0, pred_lc_dir}, 32'd1);
        chk("chooser_still_local", {31'd0, pred_taken}, 32'd1);
        tick();

        // Aliasing: 0x140 shares the local entry of 0x40.
        drive(0, 32'h140, 0, 32'h0, 0, 0, 0, 8'h00, 0);
        check_model();
        chk("alias_lc", {31'd0, pred_lc_dir}, 32'd1);
        tick();

        // Chooser training at 0x80 toward the global table.
        drive(0, 32'h80, 1, 32'h80, 1, 0, 1, 8'h00, 0);
        check_model();
        tick();
        drive(0, 32'h80, 1, 32'h80, 1, 0, 1, 8'h00, 0);
        check_model();
        tick();
        drive(0, 32'h80, 0, 32'h0, 0, 0, 0, 8'h00, 0);
        check_model();
        chk("chooser_lc_dir", {31'd0, pred_lc_dir}, 32'd1);
`ifdef BR_PRED_SPEC_GHR_EN
        chk("chooser_follows_gl", {31'd0, pred_taken}, 32'd1);
`else
        chk("chooser_follows_gl", {31'd0, pred_taken}, 32'd0);
`endif
        tick();

`ifdef BR_PRED_SPEC_GHR_EN
        // Speculative history: predict 1,0,1 then repair from a mispredict.
        do_reset();
        drive(0, 32'h40, 1, 32'h40, 1, 0, 0, 8'h00, 0);
        tick();
        drive(0, 32'h40, 1, 32'h40, 1, 0, 0, 8'h00, 0);
        tick();
        drive(1, 32'h40, 0, 32'h0, 0, 0, 0, 8'h00, 0);
        check_model();
        chk("spec_p1", {31'd0, pred_taken}, 32'd1);
        tick();
        drive(1, 32'h80, 0, 32'h0, 0, 0, 0, 8'h00, 0);
        check_model();
        chk("spec_p2", {31'd0, pred_taken}, 32'd0);
        tick();
        drive(1, 32'h40, 0, 32'h0, 0, 0, 0, 8'h00, 0);
        check_model();
        chk("spec_p3", {31'd0, pred_taken}, 32'd1);
        tick();
        drive(1, 32'h40, 1, 32'h40, 0, 0, 0, 8'h01, 1);
        check_model();
        chk("spec_ghr_shifted", {24'd0, pred_ghr}, 32'h05);
        tick();
        drive(0, 32'h40, 0, 32'h0, 0, 0, 0, 8'h00, 0);
        check_model();
        chk("spec_ghr_restored", {24'd0, pred_ghr}, 32'h02);
        tick();
`else
        // Non-speculative history and same-cycle read/write of one entry.
        do_reset();
        drive(0, 32'h200, 1, 32'h200, 1, 0, 0, 8'h00, 0);
        tick();
        drive(0, 32'h200, 1, 32'h200, 1, 0, 0, 8'h00, 0);
        tick();
        drive(1, 32'h200, 0, 32'h0, 0, 0, 0, 8'h00, 0);
        check_model();
        chk("ghr_after_two_upd", {24'd0, pred_ghr}, 32'h03);
        tick();
        drive(0, 32'h200, 0, 32'h0, 0, 0, 0, 8'h00, 0);
        check_model();
        chk("ghr_pred_valid_only", {24'd0, pred_ghr}, 32'h03);
        tick();
        drive(0, 32'h40, 1, 32'h40, 1, 0, 0, 8'h00, 0);
        check_model();
        chk("same_cycle_old_val", {31'd0, pred_lc_dir}, 32'd0);
        tick();
        drive(0, 32'h40, 0, 32'h0, 0, 0, 0, 8'h00, 0);
        check_model();
        chk("next_cycle_new_val", {31'd0, pred_lc_dir}, 32'd1);
        tick();
`endif

        // Randomised traffic over a small PC set so entries get reused.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 95)) << 2,
                  1'($urandom_range(0, 3) != 0),
                  32'($urandom_range(0, 95)) << 2,
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 3) == 0));
            check_model();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tournament_br_predictor.md
# tournament_br_predictor

Parametrised tournament branch predictor for the IF stage of the 5-stage pipeline. It generalises the fixed 2-bit `br_pred` / `tn_predictor` scheme to configurable table depths, counter widths and global-history length. A PC-indexed bimodal (local) table and a gshare (global) table are arbitrated by a PC-indexed chooser table. Prediction is combinational from the fetch PC; training happens when the branch resolves in EX/MEM.

## Interface
- `LC_IDX_BITS`, default 6: local and chooser table index width; depth = 2^LC_IDX_BITS.
- `GL_IDX_BITS`, default 8: gshare index width; equals the GHR length.
- `CTR_WIDTH`, default 2: direction-counter width, minimum 2.
- `SEL_WIDTH`, default 2: chooser-counter width, minimum 2.

Ports:
- `clk`, in, 1: clock, the single clock domain.
- `rst`, in, 1: reset; synchronous, active-high.
- `pred_valid`, in, 1: the fetched instruction is a conditional branch (from predecode).
- `pred_pc`, in, 32: fetch PC.
- `pred_taken`, out, 1: final predicted direction.
- `pred_lc_dir`, out, 1: local-table direction; carried in pipeline registers to the update port.
- `pred_gl_dir`, out, 1: global-table direction; carried to the update port.
- `pred_ghr`, out, GL_IDX_BITS: GHR snapshot used for this prediction; carried to the update port.
- `upd_valid`, in, 1: a conditional branch resolved this cycle.
- `upd_pc`, in, 32: PC of the resolved branch.
- `upd_taken`, in, 1: actual direction.
- `upd_lc_dir`, in, 1: `pred_lc_dir` captured at prediction time.
- `upd_gl_dir`, in, 1: `pred_gl_dir` captured at prediction time.
- `upd_ghr`, in, GL_IDX_BITS: `pred_ghr` captured at prediction time.
- `upd_mispredict`, in, 1: the final prediction was wrong; qualified by `upd_valid`.

## Operation
- Local index: `pred_pc[LC_IDX_BITS+1:2]`.
- Global index: `pred_pc[GL_IDX_BITS+1:2] ^ ghr`.
- The chooser uses the local index.
- A counter predicts taken when its MSB = 1.
- `pred_taken` = chooser MSB ? global direction : local direction.
- When `pred_valid` = 0, all `pred_*` outputs still reflect `pred_pc`; they are don't-care to consumers.
- Update, applied when `upd_valid`, with indices recomputed from `upd_pc` and `upd_ghr`:
  - The local counter at the local index moves toward `upd_taken`, saturating at 0 and 2^CTR_WIDTH-1.
  - The gshare counter at `upd_pc` index ^ `upd_ghr` moves toward `upd_taken`, with the same saturation.
  - The chooser changes only if `upd_lc_dir != upd_gl_dir`:
    - If `upd_gl_dir == upd_taken`, increment it, saturating.
    - Otherwise decrement it, saturating at 0.
- GHR is a shift register with the newest outcome in bit 0: `ghr <= {ghr[GL_IDX_BITS-2:0], dir}`. Update policy depends on the configuration macro (see Configuration).
- Reset values:
  - All direction counters = 2^(CTR_WIDTH-1)-1, i.e. weakly not taken (01 for width 2).
  - All chooser counters = 2^(SEL_WIDTH-1)-1, i.e. `use_lc_predictor_2`.
  - GHR = 0.
  - Consequently `pred_taken` = `pred_lc_dir` = `pred_gl_dir` = 0 and `pred_ghr` = 0 in the cycle after reset.
- `rst` overrides a simultaneous `upd_valid`.

## Timing
- Prediction has zero latency: all outputs are combinational from `pred_pc` and registered state.
- An update is written at the rising edge of the cycle where `upd_valid` = 1.
- A same-cycle read of an entry being updated returns the old value; there is no bypass.
- The new value is visible to prediction one cycle after the update.
- At most one prediction and one update per cycle; they are independent and may target the same entries.

## Configuration
- Macro: `BR_PRED_SPEC_GHR_EN`.
- Defined (speculative GHR):
  - On `pred_valid`, the GHR shifts in `pred_taken`.
  - On `upd_valid && upd_mispredict`, the GHR is restored to `{upd_ghr[GL_IDX_BITS-2:0], upd_taken}`.
  - Restore has priority over a same-cycle speculative shift.
- Undefined (non-speculative GHR): the GHR shifts in `upd_taken` only on `upd_valid`, and `pred_valid` does not affect it.
- Table behaviour is identical in both modes.

## Structure
- Additions to `rv32i_types`:
  - Default-parameter localparams.
  - A packed `br_pred_info_t` struct {`taken`, `lc_dir`, `gl_dir`, `ghr`} for pipeline registers. Its `ghr` field is sized by the package default.
- Existing `br_pred` and `tn_predictor` enums remain valid for the 2-bit defaults.
- One sub-module, `br_counter_table`:
  - Parameters IDX_BITS and WIDTH, plus a reset value.
  - Flop array with one combinational read port and one saturating increment/decrement write port.
  - Instantiated three times: local, global, chooser.

## Test plan
- Reset: assert `rst` for one cycle, then `pred_pc`=0x40 → `pred_taken`=0, `pred_lc_dir`=0, `pred_gl_dir`=0, `pred_ghr`=0.
- Local saturation: three updates at PC 0x40 with `upd_taken`=1 and `upd_lc_dir`=`upd_gl_dir` → local counter 01→10→11→11; predicting 0x40 gives `pred_lc_dir`=1 after the first update, and the chooser is unchanged.
- Chooser training: two updates with `upd_lc_dir`=0, `upd_gl_dir`=1, `upd_taken`=1 → chooser 01→10→11, and `pred_taken` follows the global direction.
- Aliasing: an update to PC 0x40 and a prediction at PC 0x140 with LC_IDX_BITS=6 → both use the same local entry.
- GHR, macro defined: three `pred_valid` cycles predicting 1,0,1, then a mispredict with `upd_ghr`=0x01, `upd_taken`=0 → GHR goes 0x05, then restores to 0x02.
- GHR, macro undefined: updates with taken 1,1 → GHR=0x03; `pred_valid` alone leaves the GHR unchanged; simultaneous same-entry update and read returns the old value.
